// File: rtl/midi_out_tx_if.sv
// midi_out_tx_if: message handshake bundle between a MIDI message source and midi_out_tx.
// master drives the message and msg_valid; slave returns msg_ready.
interface midi_out_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;

  modport master (
    output msg_valid,
    output msg_status,
    output msg_data1,
    output msg_data2,
    input  msg_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_status,
    input  msg_data1,
    input  msg_data2,
    output msg_ready
  );
endinterface

// File: rtl/midi_out_tx.sv
// midi_out_tx: MIDI message serialiser, 8N1 frames on midi_txd (optional MIDI_TX_RUNNING_STATUS_EN).
// Latency: start bit from the cycle after accept; an L-byte message is busy for L*10*CLKS_PER_BIT cycles.
// Backpressure: msg_ready only in IDLE; msg_* inputs are ignored while a message is in flight.
module midi_out_tx #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic         reg_clk,
  input  logic         reset_reg_N,
  midi_out_tx_if.slave msg,
  output logic         midi_txd,
  output logic         busy,
  output logic         byte_sent
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;

  logic [2:0]      state;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      byte_idx;
  logic [1:0]      byte_cnt;
  logic [2:0][7:0] byte_buf;
  logic [7:0]      shift_q;
  logic            txd_q;

  logic            accept;
  logic [7:0]      data1_m;
  logic [7:0]      data2_m;
  logic [1:0]      full_len;
  logic            omit_status;
  logic [1:0]      load_len;
  logic [2:0][7:0] load_buf;
  logic [7:0]      cur_byte;
  logic            bit_end;
  logic            last_byte;

  function automatic logic [1:0] msg_len(input logic [7:0] s);
    logic [1:0] len;
    len = 2'd1;
    case (s[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
      4'hC, 4'hD:                   len = 2'd2;
      4'hF: begin
        case (s[3:0])
          4'h1, 4'h3: len = 2'd2;
          4'h2:       len = 2'd3;
          default:    len = 2'd1;
        endcase
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

  assign accept = msg.msg_valid && (state == ST_IDLE);

`ifdef MIDI_TX_RUNNING_STATUS_EN
  // Remembers the last channel-voice status; system common/exclusive cancels it, real-time does not.
  logic [7:0] rs_status;
  logic       rs_vld;

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rs_status <= 8'h00;
      rs_vld    <= 1'b0;
    end else if (accept && msg.msg_status[7]) begin
      if (msg.msg_status[7:4] != 4'hF) begin
        rs_status <= msg.msg_status;
        rs_vld    <= 1'b1;
      end else if (!msg.msg_status[3]) begin
        rs_vld    <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    data1_m     = msg.msg_data1 & 8'h7F;
    data2_m     = msg.msg_data2 & 8'h7F;
    full_len    = msg_len(msg.msg_status);
    omit_status = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    omit_status = rs_vld && (msg.msg_status == rs_status) && (msg.msg_status[7:4] != 4'hF);
`endif
    if (omit_status) begin
      load_len = 2'(full_len - 2'd1);
      load_buf = {8'h00, data2_m, data1_m};
    end else begin
      load_len = full_len;
      load_buf = {data2_m, data1_m, msg.msg_status};
    end
  end

  assign cur_byte  = byte_buf[byte_idx];
  assign bit_end   = (bit_cnt == '0);
  assign last_byte = (2'(byte_idx + 2'd1) == byte_cnt);

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      byte_cnt <= 2'd0;
      byte_buf <= '0;
      shift_q  <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!msg.msg_status[7]) begin
              state <= ST_DROP;
            end else begin
              state    <= ST_START;
              txd_q    <= 1'b0;
              bit_cnt  <= BIT_RELOAD;
              byte_idx <= 2'd0;
              byte_cnt <= load_len;
              byte_buf <= load_buf;
            end
          end
        end
        ST_DROP: begin
          state <= ST_IDLE;
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_cnt <= BIT_RELOAD;
            bit_idx <= 3'd0;
            txd_q   <= cur_byte[0];
            shift_q <= cur_byte >> 1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd_q <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            // Next frame follows the stop bit directly, no idle gap inside a message.
            if (last_byte) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_START;
              byte_idx <= byte_idx + 2'd1;
              bit_cnt  <= BIT_RELOAD;
              txd_q    <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  assign msg.msg_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign byte_sent     = (state == ST_STOP) && bit_end;
  assign midi_txd      = txd_q;

  a_line_idle_high: assert property (
    @(posedge reg_clk) disable iff (!reset_reg_N)
      ((state == ST_IDLE) || (state == ST_DROP)) |-> midi_txd
  );

  a_len_nonzero: assert property (
    @(posedge reg_clk) disable iff (!reset_reg_N)
      (state == ST_START) |-> (byte_cnt != 2'd0)
  );

endmodule

// File: tb/tb_midi_out_tx.sv
// Directed bench for midi_out_tx at CLKS_PER_BIT=16: decodes midi_txd mid-bit and checks framing and timing.
module tb_midi_out_tx;
  localparam int C     = 16;
  localparam int FRAME = 10 * C;

  logic reg_clk = 1'b0;
  logic reset_reg_N;
  logic midi_txd;
  logic busy;
  logic byte_sent;

  int errors = 0;
  int checks = 0;

  midi_out_tx_if msg_if ();

  midi_out_tx #(.CLKS_PER_BIT(C)) dut (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .msg         (msg_if),
    .midi_txd    (midi_txd),
    .busy        (busy),
    .byte_sent   (byte_sent)
  );

  always #5 reg_clk = ~reg_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns right after the accepting posedge.
  task automatic offer(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int guard;
    guard = 0;
    while (msg_if.msg_ready !== 1'b1 && guard < 4000) begin
      @(negedge reg_clk);
      guard++;
    end
    if (guard >= 4000) check("ready_timeout", 32'd0, 32'd1);
    msg_if.msg_valid  = 1'b1;
    msg_if.msg_status = s;
    msg_if.msg_data1  = d1;
    msg_if.msg_data2  = d2;
    @(posedge reg_clk);
  endtask

  task automatic run_msg(input string tag, input logic [7:0] s, input logic [7:0] d1,
                         input logic [7:0] d2, input int exp_len,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] exp_b [3];
    logic [7:0] got_b [3];
    int total, busy_n, pulses, low_n, f, j;
    bit frame_ok, pos_ok;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2;
    for (int i = 0; i < 3; i++) got_b[i] = 8'h00;
    total    = (exp_len == 0) ? 1 : exp_len * FRAME;
    busy_n   = 0;
    pulses   = 0;
    low_n    = 0;
    frame_ok = 1'b1;
    pos_ok   = 1'b1;
    offer(s, d1, d2);
    for (int k = 1; k <= total + 3; k++) begin
      @(negedge reg_clk);
      // While busy, keep offering junk that must not be taken.
      if (k == 1 && exp_len > 0) begin
        msg_if.msg_status = 8'hF8;
        msg_if.msg_data1  = 8'h55;
        msg_if.msg_data2  = 8'h55;
      end
      if ((k == 1 && exp_len == 0) || k == 20) msg_if.msg_valid = 1'b0;
      if (busy) busy_n++;
      if (byte_sent) begin
        pulses++;
        if ((k % FRAME) != 0 || k > total) pos_ok = 1'b0;
      end
      if (midi_txd !== 1'b1) low_n++;
      if (k == 1) begin
        check({tag, "_ready_low"}, 32'(msg_if.msg_ready), 32'd0);
        if (exp_len > 0) check({tag, "_start_edge"}, 32'(midi_txd), 32'd0);
      end
      if (k == total + 1) begin
        check({tag, "_ready_back"}, 32'(msg_if.msg_ready), 32'd1);
        check({tag, "_line_idle"}, 32'(midi_txd), 32'd1);
      end
      f = (k - 1) / FRAME;
      j = ((k - 1) % FRAME) / C;
      if (f < exp_len && ((k - 1) % C) == C / 2) begin
        if (j == 0) begin
          if (midi_txd !== 1'b0) frame_ok = 1'b0;
        end else if (j == 9) begin
          if (midi_txd !== 1'b1) frame_ok = 1'b0;
        end else begin
          got_b[f][j-1] = midi_txd;
        end
      end
    end
    for (int i = 0; i < exp_len; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
    check({tag, "_framing"}, 32'(frame_ok), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(total));
    check({tag, "_byte_sent_count"}, 32'(pulses), 32'(exp_len));
    check({tag, "_byte_sent_timing"}, 32'(pos_ok), 32'd1);
    if (exp_len == 0) check({tag, "_line_quiet"}, 32'(low_n), 32'd0);
  endtask

  initial begin
    reset_reg_N       = 1'b0;
    msg_if.msg_valid  = 1'b0;
    msg_if.msg_status = 8'h00;
    msg_if.msg_data1  = 8'h00;
    msg_if.msg_data2  = 8'h00;
    repeat (3) @(negedge reg_clk);
    check("rst_txd", 32'(midi_txd), 32'd1);
    check("rst_ready", 32'(msg_if.msg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte_sent", 32'(byte_sent), 32'd0);
    reset_reg_N = 1'b1;
    repeat (2) @(negedge reg_clk);

    run_msg("note_on",  8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);
    run_msg("prog_chg", 8'hC5, 8'h10, 8'h7F, 2, 8'hC5, 8'h10, 8'h00);
    run_msg("rt_clock", 8'hF8, 8'h12, 8'h34, 1, 8'hF8, 8'h00, 8'h00);
    run_msg("mask",     8'hB0, 8'hFF, 8'h80, 3, 8'hB0, 8'h7F, 8'h00);
    run_msg("drop",     8'h45, 8'h11, 8'h22, 0, 8'h00, 8'h00, 8'h00);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    run_msg("after_drop", 8'hB0, 8'h01, 8'h02, 2, 8'h01, 8'h02, 8'h00);
`else
    run_msg("after_drop", 8'hB0, 8'h01, 8'h02, 3, 8'hB0, 8'h01, 8'h02);
`endif
    run_msg("rs_first", 8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);
    run_msg("rs_rt",    8'hF8, 8'h00, 8'h00, 1, 8'hF8, 8'h00, 8'h00);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    run_msg("rs_repeat", 8'h90, 8'h3E, 8'h64, 2, 8'h3E, 8'h64, 8'h00);
`else
    run_msg("rs_repeat", 8'h90, 8'h3E, 8'h64, 3, 8'h90, 8'h3E, 8'h64);
`endif
    run_msg("song_pos",   8'hF2, 8'h01, 8'h02, 3, 8'hF2, 8'h01, 8'h02);
    run_msg("rs_cleared", 8'h90, 8'h40, 8'h00, 3, 8'h90, 8'h40, 8'h00);

    // Reset during data bit 0 of the second frame, which is a 0 in both builds.
    offer(8'h90, 8'h3C, 8'h64);
    for (int k = 1; k <= FRAME + C + 8; k++) begin
      @(negedge reg_clk);
      if (k == 1) msg_if.msg_valid = 1'b0;
    end
    check("pre_rst_txd", 32'(midi_txd), 32'd0);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset_reg_N = 1'b0;
    #1;
    check("mid_rst_txd", 32'(midi_txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge reg_clk);
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    @(negedge reg_clk);
    check("post_rst_ready", 32'(msg_if.msg_ready), 32'd1);
    check("post_rst_txd", 32'(midi_txd), 32'd1);
    run_msg("post_rst", 8'h90, 8'h3C, 8'h64, 3, 8'h90, 8'h3C, 8'h64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
